sigmoid_inverse_seq: RTL and testbench

- Sequential inverse-sigmoid (logit) unit. It maps a sigmoid-domain value y back to the pre-activation x for the same 2-segment piecewise-linear model the forward sigmoid uses.
- Used on the training/backprop path to recover x from stored activations, and in the bench as the round-trip checker for the forward sigmoid.
- Input y is in the forward sigmoid's output format: signed 48-bit, 13 fraction bits, 8192 = 1.0.
- Output x is in the forward sigmoid's input format: 18-bit sign-magnitude, 1 sign, 4 integer, 13 fraction bits.
- Division by the segment slope uses a multi-cycle restoring divider.

---
 rtl/sigmoid_inverse_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sigmoid_inverse_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_inverse_seq.sv
// sigmoid_inverse_seq: inverse of the 2-segment piecewise-linear sigmoid.
// Takes a Q.13 sigmoid value y and recovers the sign-magnitude Q4.13 pre-activation x.
// The recovered magnitude is floor((y' - C2) * 8192 / C1), computed by a 17-step restoring divider.
// Output registers load on the first DONE cycle, and out_valid rises on the following cycle.
module sigmoid_inverse_seq #(
  parameter logic [15:0] C1_A  = 16'd1696,
  parameter logic [15:0] C2_A  = 16'd4096,
  parameter logic [15:0] C1_B  = 16'd215,
  parameter logic [15:0] C2_B  = 16'd6466,
  parameter logic [15:0] Y_BRK = 16'd6810,
  parameter logic [15:0] Y_SAT = 16'd8186
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] x_out,
  output logic [1:0]  region
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  // working registers
  logic [47:0] y_r;
  logic        sign_r;
  logic [1:0]  seg_r;
  logic [16:0] q_r;
  logic [27:0] rem_r;
  logic [16:0] dvd_r;
  logic [15:0] dsr_r;
  logic [4:0]  cnt_r;

  // output registers
  logic        in_ready_r;
  logic        out_valid_r;
  logic [17:0] x_out_r;
  logic [1:0]  region_r;

  // PREP datapath
  logic [13:0] y_clamp_s;
  logic [13:0] y_fold_s;
  logic        fold_sign_s;
  logic        sat_s;
  logic [1:0]  seg_s;
  logic [15:0] c1_s;
  logic [15:0] c2_s;
  logic [15:0] diff_s;
  logic [26:0] dividend_s;
  logic        ovf_s;

  // divider step
  logic [27:0] shifted_s;
  logic [28:0] trial_s;
  logic        ge_s;

  // output control
  logic        in_ready_nxt_s;
  logic        out_valid_nxt_s;
  logic        load_s;
  logic [17:0] x_nxt_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign x_out     = x_out_r;
  assign region    = region_r;

  // Clamp, fold and segment-select the latched y; build dividend and divisor.
  always_comb begin
    y_clamp_s   = 14'd0;
    y_fold_s    = 14'd0;
    fold_sign_s = 1'b0;
    sat_s       = 1'b0;
    seg_s       = 2'b00;
    c1_s        = C1_A;
    c2_s        = C2_A;
    diff_s      = 16'd0;
    dividend_s  = 27'd0;
    ovf_s       = 1'b0;

    if (y_r[47]) begin
      y_clamp_s = 14'd0;
    end else if (y_r > 48'd8192) begin
      y_clamp_s = 14'd8192;
    end else begin
      y_clamp_s = y_r[13:0];
    end

    if (y_clamp_s >= 14'd4096) begin
      fold_sign_s = 1'b0;
      y_fold_s    = y_clamp_s;
    end else begin
      fold_sign_s = 1'b1;
      y_fold_s    = 14'd8192 - y_clamp_s;
    end

    if ({2'b00, y_fold_s} >= Y_SAT) begin
      sat_s = 1'b1;
      seg_s = 2'b00;
      c1_s  = C1_B;
      c2_s  = C2_B;
    end else if ({2'b00, y_fold_s} < Y_BRK) begin
      sat_s = 1'b0;
      seg_s = 2'b10;
      c1_s  = C1_A;
      c2_s  = C2_A;
    end else begin
      sat_s = 1'b0;
      seg_s = 2'b11;
      c1_s  = C1_B;
      c2_s  = C2_B;
    end

    if ({2'b00, y_fold_s} >= c2_s) begin
      diff_s = {2'b00, y_fold_s} - c2_s;
    end else begin
      diff_s = 16'd0;
    end

    dividend_s = {diff_s[13:0], 13'd0};
    // quotient would not fit in 17 bits
    ovf_s = ({6'd0, dividend_s} >= {c1_s, 17'd0});
  end

  // One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    shifted_s = {rem_r[26:0], dvd_r[16]};
    trial_s   = {1'b0, shifted_s} - {13'd0, dsr_r};
    ge_s      = ~trial_s[28];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_nxt_s = PREP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PREP: begin
        if (sat_s || ovf_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DIV;
        end
      end
      DIV: begin
        if (cnt_r == 5'd16) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DIV;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; the result is loaded on the first DONE cycle.
  always_comb begin
    in_ready_nxt_s  = (state_nxt_s == IDLE);
    out_valid_nxt_s = (state_r == DONE) && (state_nxt_s == DONE);
    load_s          = (state_r == DONE) && !out_valid_r;
    // no negative zero
    x_nxt_s         = {sign_r & (q_r != 17'd0), q_r};
  end

  // Input latch, segment setup and the divider iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r    <= 48'd0;
      sign_r <= 1'b0;
      seg_r  <= 2'b00;
      q_r    <= 17'd0;
      rem_r  <= 28'd0;
      dvd_r  <= 17'd0;
      dsr_r  <= 16'd0;
      cnt_r  <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            y_r <= y_in;
          end
        end
        PREP: begin
          sign_r <= fold_sign_s;
          seg_r  <= seg_s;
          // top 10 bits preloaded so only the 17 quotient bits need steps
          rem_r  <= {18'd0, dividend_s[26:17]};
          dvd_r  <= dividend_s[16:0];
          dsr_r  <= c1_s;
          cnt_r  <= 5'd0;
          if (sat_s) begin
            q_r <= 17'h10000;
          end else if (ovf_s) begin
            q_r <= 17'h1FFFF;
          end else begin
            q_r <= 17'd0;
          end
        end
        DIV: begin
          rem_r <= ge_s ? trial_s[27:0] : shifted_s;
          dvd_r <= {dvd_r[15:0], 1'b0};
          q_r   <= {q_r[15:0], ge_s};
          cnt_r <= cnt_r + 5'd1;
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      x_out_r     <= 18'd0;
      region_r    <= 2'b00;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      if (load_s) begin
        x_out_r  <= x_nxt_s;
        region_r <= seg_r;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_inverse_seq.sv
// Bench for sigmoid_inverse_seq: scoreboard of expected {region, x_out}, latency,
// backpressure, mid-divide reset and a forward/inverse round-trip sweep.
module tb_sigmoid_inverse_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] x_out;
  logic [1:0]  region;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] sb_q[$];

  sigmoid_inverse_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .region    (region)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference inverse: returns {region, x_out}.
  function automatic logic [19:0] ref_inv(input logic signed [47:0] y);
    longint yv, yc, yp, c1, c2, d, q;
    logic s;
    logic [1:0] rg;
    yv = longint'(y);
    if (yv < 0) yc = 0;
    else if (yv > 8192) yc = 8192;
    else yc = yv;
    if (yc >= 4096) begin s = 1'b0; yp = yc; end
    else begin s = 1'b1; yp = 8192 - yc; end
    if (yp >= 8186) begin
      rg = 2'b00;
      q  = 65536;
    end else begin
      if (yp < 6810) begin rg = 2'b10; c1 = 1696; c2 = 4096; end
      else begin rg = 2'b11; c1 = 215; c2 = 6466; end
      d = yp - c2;
      if (d < 0) d = 0;
      q = (d * 8192) / c1;
      if (q > 131071) q = 131071;
    end
    if (q == 0) s = 1'b0;
    return {rg, s, q[16:0]};
  endfunction

  // Reference forward sigmoid with the same two segments; |x| >= 8.0 saturates.
  function automatic logic [47:0] fwd(input logic [17:0] x);
    longint m, yp, yv;
    m = longint'(x[16:0]);
    if (m < 13107) yp = 4096 + (1696 * m) / 8192;
    else if (m < 65536) yp = 6466 + (215 * m) / 8192;
    else yp = 8192;
    yv = x[17] ? (8192 - yp) : yp;
    return yv[47:0];
  endfunction

  function automatic int sm_to_int(input logic [17:0] x);
    int m;
    m = int'(x[16:0]);
    return x[17] ? -m : m;
  endfunction

  // Send one y, wait for its result, compare against the scoreboard, optionally stall.
  task automatic run_one(input logic [47:0] y, input int exp_lat, input int hold,
                         input logic pend, input logic [47:0] pend_y,
                         input string tag, output logic [17:0] obs);
    int n;
    logic [19:0] e;
    logic [17:0] x_hold;
    logic [1:0]  r_hold;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check_val({tag, "_rdy_to"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    y_in     = y;
    sb_q.push_back(ref_inv(y));
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin @(negedge clk); n++; end
    check_val({tag, "_valid_to"}, {31'd0, out_valid}, 32'd1);
    if (exp_lat > 0) check_val({tag, "_lat"}, n, exp_lat);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 20'hFFFFF;
    check_val({tag, "_x"}, {14'd0, x_out}, {14'd0, e[17:0]});
    check_val({tag, "_region"}, {30'd0, region}, {30'd0, e[19:18]});
    obs    = x_out;
    x_hold = x_out;
    r_hold = region;
    if (pend) begin
      in_valid = 1'b1;
      y_in     = pend_y;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "_hold_x"}, {14'd0, x_out}, {14'd0, x_hold});
      check_val({tag, "_hold_region"}, {30'd0, region}, {30'd0, r_hold});
      check_val({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
      check_val({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
    check_val({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Watchdog.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus.
  initial begin
    logic [17:0] obs;
    logic [17:0] xin;
    int err;
    int bound;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y_in      = 48'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_x_out", {14'd0, x_out}, 32'd0);
    check_val("rst_region", {30'd0, region}, 32'd0);

    run_one(48'd4096, 19, 0, 1'b0, 48'd0, "zero", obs);
    run_one(48'd4944, 19, 0, 1'b0, 48'd0, "segA_pos", obs);
    run_one(48'd3248, 19, 0, 1'b0, 48'd0, "segA_neg", obs);
    run_one(48'd7326, 19, 0, 1'b0, 48'd0, "segB_pos", obs);
    run_one(48'd866,  19, 0, 1'b0, 48'd0, "segB_neg", obs);
    run_one(48'd8192, 2, 0, 1'b0, 48'd0, "sat_pos", obs);
    run_one(48'd0,    2, 0, 1'b0, 48'd0, "sat_neg", obs);
    run_one(48'hFFFF_FFFF_FFFB, 2, 0, 1'b0, 48'd0, "clamp_neg", obs);
    run_one(48'd9000, 2, 0, 1'b0, 48'd0, "clamp_hi", obs);

    // backpressure with a pending input held during DONE
    run_one(48'd4944, 19, 10, 1'b1, 48'd7326, "bp", obs);
    run_one(48'd7326, 19, 0, 1'b0, 48'd0, "pend", obs);
    run_one(48'd4944, 19, 0, 1'b0, 48'd0, "pre_rst", obs);

    // reset on the 8th DIV cycle
    n_checks = n_checks;
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    y_in     = 48'd7326;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_x_out", {14'd0, x_out}, 32'd0);
    run_one(48'd4944, 19, 0, 1'b0, 48'd0, "post_rst", obs);

    // round trip through the forward model
    for (int m = 0; m <= 131071; m += 512) begin
      for (int s = 0; s < 2; s++) begin
        xin = {s[0], m[16:0]};
        run_one(fwd(xin), 0, 0, 1'b0, 48'd0, "rt", obs);
        if (m >= 65536) begin
          check_val("rt_sat", {14'd0, obs}, (s == 1) ? 32'h30000 : 32'h10000);
        end else begin
          err   = sm_to_int(obs) - sm_to_int(xin);
          if (err < 0) err = -err;
          bound = (m < 13107) ? 6 : 40;
          if (err > bound) $display("rt_err detail: x=0x%0h x_out=0x%0h", xin, obs);
          check_val("rt_err", {31'd0, (err <= bound)}, 32'd1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
